// File: rtl/regfile_wb_arbiter.sv
// Two-source round-robin writeback arbiter for the register file write port.
// One registered commit per cycle; x0 writes are accepted but never reach the file.

module regfile_wb_stall_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear beats increment; the counter sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (inc && cnt_q != '1)  cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arb_en,
  input  logic              clr_stats,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [ADDR_W-1:0] in0_rd,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [ADDR_W-1:0] in1_rd,
  input  logic [DATA_W-1:0] in1_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  in0_stalls,
  output logic [CNT_W-1:0]  in1_stalls
);
  localparam int NUM_SRC = 2;

  logic [NUM_SRC-1:0]             valid, gnt, stall;
  logic [NUM_SRC-1:0][ADDR_W-1:0] rd;
  logic [NUM_SRC-1:0][DATA_W-1:0] data;
  logic [NUM_SRC-1:0][CNT_W-1:0]  stalls;

  logic              rr_ptr_q, rr_ptr_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              sel;

  assign valid = {in1_valid, in0_valid};
  assign rd    = {in1_rd, in0_rd};
  assign data  = {in1_data, in0_data};

  // rr_ptr names the source that wins a tie.
  always_comb begin
    gnt = '0;
    if (!reset && arb_en) begin
      if (valid[0] && (!valid[1] || !rr_ptr_q)) gnt[0] = 1'b1;
      else if (valid[1])                        gnt[1] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt[0])      rr_ptr_d = 1'b1;
    else if (gnt[1]) rr_ptr_d = 1'b0;
    sel        = gnt[1];
    rf_we_d    = (|gnt) && (rd[sel] != '0);
    rf_rd_d    = rf_we_d ? rd[sel]   : '0;
    rf_wdata_d = rf_we_d ? data[sel] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign stall = valid & ~gnt & {NUM_SRC{~reset}};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_stall
    regfile_wb_stall_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_stats),
      .inc   (stall[i]),
      .cnt   (stalls[i])
    );
  end

  assign in0_ready  = gnt[0];
  assign in1_ready  = gnt[1];
  assign rf_we      = rf_we_q;
  assign rf_rd      = rf_rd_q;
  assign rf_wdata   = rf_wdata_q;
  assign in0_stalls = stalls[0];
  assign in1_stalls = stalls[1];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model (default and CNT_W=2 copies).

module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset, arb_en, clr_stats;
  logic        in0_valid, in1_valid;
  logic [4:0]  in0_rd, in1_rd;
  logic [31:0] in0_data, in1_data;

  logic        in0_ready, in1_ready, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [15:0] in0_stalls, in1_stalls;

  logic        s_in0_ready, s_in1_ready, s_rf_we;
  logic [4:0]  s_rf_rd;
  logic [31:0] s_rf_wdata;
  logic [1:0]  s_in0_stalls, s_in1_stalls;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset), .arb_en(arb_en), .clr_stats(clr_stats),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_rd(in0_rd), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_rd(in1_rd), .in1_data(in1_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .in0_stalls(in0_stalls), .in1_stalls(in1_stalls)
  );

  regfile_wb_arbiter #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .arb_en(arb_en), .clr_stats(clr_stats),
    .in0_valid(in0_valid), .in0_ready(s_in0_ready), .in0_rd(in0_rd), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(s_in1_ready), .in1_rd(in1_rd), .in1_data(in1_data),
    .rf_we(s_rf_we), .rf_rd(s_rf_rd), .rf_wdata(s_rf_wdata),
    .in0_stalls(s_in0_stalls), .in1_stalls(s_in1_stalls)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: who wins this cycle, what lands next cycle, raw stall counts.
  initial begin : model
    int pref, w, c0, c1;
    logic       e_we;
    logic [4:0] e_rd;
    logic [31:0] e_wd;
    pref = 0; c0 = 0; c1 = 0; e_we = 0; e_rd = '0; e_wd = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      w = -1;
      if (!reset && arb_en) begin
        if (in0_valid && in1_valid) w = pref;
        else if (in0_valid)         w = 0;
        else if (in1_valid)         w = 1;
      end
      chk("m_in0_ready", in0_ready, w == 0);
      chk("m_in1_ready", in1_ready, w == 1);
      chk("m_s_in0_ready", s_in0_ready, w == 0);
      chk("m_s_in1_ready", s_in1_ready, w == 1);
      chk("m_rf_we", rf_we, e_we);
      chk("m_rf_rd", rf_rd, e_rd);
      chk("m_rf_wdata", rf_wdata, e_wd);
      chk("m_s_rf_we", s_rf_we, e_we);
      chk("m_in0_stalls", in0_stalls, (c0 > 65535) ? 65535 : c0);
      chk("m_in1_stalls", in1_stalls, (c1 > 65535) ? 65535 : c1);
      chk("m_s_in0_stalls", s_in0_stalls, (c0 > 3) ? 3 : c0);
      chk("m_s_in1_stalls", s_in1_stalls, (c1 > 3) ? 3 : c1);
      if (reset) begin
        pref = 0; c0 = 0; c1 = 0; e_we = 0; e_rd = '0; e_wd = '0;
      end else begin
        e_we = 0; e_rd = '0; e_wd = '0;
        if (w >= 0) begin
          pref = 1 - w;
          if (((w == 0) ? in0_rd : in1_rd) != 5'd0) begin
            e_we = 1;
            e_rd = (w == 0) ? in0_rd : in1_rd;
            e_wd = (w == 0) ? in0_data : in1_data;
          end
        end
        if (clr_stats) begin
          c0 = 0; c1 = 0;
        end else begin
          if (in0_valid && w != 0) c0++;
          if (in1_valid && w != 1) c1++;
        end
      end
    end
  end

  initial begin : stim
    logic x0, x1;
    reset = 1; arb_en = 1; clr_stats = 0;
    in0_valid = 0; in0_rd = '0; in0_data = '0;
    in1_valid = 0; in1_rd = '0; in1_data = '0;
    repeat (2) step();

    // Single source
    reset = 0; in0_valid = 1; in0_rd = 5'd5; in0_data = 32'hDEADBEEF;
    #1 chk("single_ready", in0_ready, 1);
    step(); in0_valid = 0;
    #1 chk("single_we", rf_we, 1);
    chk("single_rd", rf_rd, 5);
    chk("single_wdata", rf_wdata, 32'hDEADBEEF);
    step();
    #1 chk("single_we_after", rf_we, 0);

    // Contention after reset
    step(); reset = 1;
    step(); reset = 0;
    in0_valid = 1; in0_rd = 5'd1; in0_data = 32'hA;
    in1_valid = 1; in1_rd = 5'd2; in1_data = 32'hB;
    for (int k = 0; k < 4; k++) begin
      #1 chk("cont_in0_ready", in0_ready, (k % 2) == 0);
      chk("cont_in1_ready", in1_ready, (k % 2) == 1);
      if (k > 0) chk("cont_rf_rd", rf_rd, ((k - 1) % 2 == 0) ? 1 : 2);
      step();
    end
    in0_valid = 0; in1_valid = 0;
    #1 chk("cont_rf_rd_last", rf_rd, 2);
    chk("cont_in0_stalls", in0_stalls, 2);
    chk("cont_in1_stalls", in1_stalls, 2);
    chk("cont_s_in0_stalls", s_in0_stalls, 2);

    // x0 write
    step(); in1_valid = 1; in1_rd = 5'd0; in1_data = 32'h1234;
    #1 chk("x0_ready", in1_ready, 1);
    step(); in1_valid = 0; clr_stats = 1;
    #1 chk("x0_we", rf_we, 0);
    chk("x0_rd", rf_rd, 0);
    chk("x0_wdata", rf_wdata, 0);

    // arb_en low for 3 cycles
    step(); clr_stats = 0; arb_en = 0; in1_valid = 1; in1_rd = 5'd3; in1_data = 32'hC0FFEE;
    #1 chk("dis_ready", in1_ready, 0);
    repeat (2) begin
      step();
      #1 chk("dis_ready", in1_ready, 0);
    end
    step(); arb_en = 1;
    #1 chk("reen_ready", in1_ready, 1);
    chk("dis_stalls", in1_stalls, 3);
    step(); in1_valid = 0;
    #1 chk("reen_we", rf_we, 1);
    chk("reen_rd", rf_rd, 3);

    // Saturation and clear
    step(); clr_stats = 1; arb_en = 0; in0_valid = 1; in0_rd = 5'd9; in0_data = 32'h99;
    repeat (5) begin
      step(); clr_stats = 0;
    end
    step(); clr_stats = 1;
    #1 chk("sat_s_in0_stalls", s_in0_stalls, 3);
    chk("sat_in0_stalls", in0_stalls, 5);
    step(); clr_stats = 0; arb_en = 1;
    #1 chk("clr_s_in0_stalls", s_in0_stalls, 0);
    chk("clr_in0_stalls", in0_stalls, 0);
    chk("clr_grant", in0_ready, 1);

    // Reset mid-stream
    step(); in0_rd = 5'd7; in0_data = 32'h77;
    #1 chk("rst_accept", in0_ready, 1);
    step(); reset = 1; in1_valid = 1; in1_rd = 5'd4; in1_data = 32'h44;
    #1 chk("rst_in0_ready", in0_ready, 0);
    chk("rst_in1_ready", in1_ready, 0);
    chk("rst_prev_we", rf_we, 1);
    chk("rst_prev_rd", rf_rd, 7);
    step(); reset = 0;
    #1 chk("rst_we", rf_we, 0);
    chk("rst_in0_stalls", in0_stalls, 0);
    chk("rst_in1_stalls", in1_stalls, 0);
    chk("rst_pref_in0", in0_ready, 1);
    chk("rst_pref_in1", in1_ready, 0);
    step(); in0_valid = 0;
    #1 chk("rst_post_rd", rf_rd, 7);

    // Randomized run; sources hold their request until it transfers.
    x0 = 1; x1 = 1;
    for (int i = 0; i < 3000; i++) begin
      step();
      reset     = ($urandom_range(0, 99) == 0);
      arb_en    = ($urandom_range(0, 9) != 0);
      clr_stats = ($urandom_range(0, 39) == 0);
      if (!in0_valid || x0) begin
        in0_valid = ($urandom_range(0, 2) != 0);
        in0_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        in0_data  = $urandom;
      end
      if (!in1_valid || x1) begin
        in1_valid = ($urandom_range(0, 2) != 0);
        in1_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        in1_data  = $urandom;
      end
      #1;
      x0 = in0_valid & in0_ready;
      x1 = in1_valid & in1_ready;
    end
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
